pipe_stage_buf: RTL
===================

// Module: pipe_stage_buf
// PURPOSE
//   Parametrised inter-stage pipeline register (IF/ID and later stages) with valid/ready handshake.
//   Optional 2-entry skid buffer; hazard-unit hold (stall) and branch flush.
//   Flush always wins over hold.
//   Empty stage presents a NOP bubble on out_data.
//   Sits between producer stage (fetch) and consumer stage (decode).
// PARAMETERS
//   DATA_W       32     width of instruction/payload word
//   PC_W         32     width of PC+1 sideband carried with the payload
//   BUBBLE_DATA  32'h0  value driven on out_data while out_valid=0 (NOP encoding)
//   SKID         1      1: 2-entry skid buffer, registered in_ready; 0: single entry, combinational in_ready
//   CNT_W        8      width of saturating flush-drop counter
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   in_valid     in   1       upstream entry valid
//   in_ready     out  1       stage can accept an entry this cycle
//   in_data      in   DATA_W  upstream instruction
//   in_pc        in   PC_W    upstream PC+1
//   out_valid    out  1       main entry valid
//   out_ready    in   1       downstream can accept
//   out_data     out  DATA_W  main entry instruction, else BUBBLE_DATA
//   out_pc       out  PC_W    main entry PC+1, else 0
//   hold         in   1       stall from hazard unit; treated as out_ready=0
//   flush        in   1       discard all held entries at next edge
//   occupancy    out  2       valid entries held (0..2; max 1 when SKID=0)
//   drop_cnt     out  CNT_W   saturating count of valid entries discarded by flush
// BEHAVIOUR
//   Reset (rst_n=0, async): both entry valids=0, drop_cnt=0.
//     Outputs: out_valid=0, out_data=BUBBLE_DATA, out_pc=0, occupancy=0, in_ready=1.
//   Storage: main entry M drives the outputs; skid entry S exists only when SKID=1.
//   Handshakes:
//     up_fire = in_valid & in_ready.
//     dn_fire = out_valid & out_ready & ~hold.
//     Latency in->out: 1 cycle.
//     Full throughput (1 entry/cycle) when downstream never stalls.
//   in_ready:
//     SKID=1: in_ready = ~S.valid, from register state only; no combinational path from out_ready/hold.
//     SKID=0: in_ready = ~M.valid | (out_ready & ~hold).
//   Transitions at clock edge, flush=0:
//     M empty, up_fire                      -> M<=in.
//     M full, dn_fire, S empty, up_fire     -> M<=in.
//     M full, dn_fire, S empty, no up_fire  -> M empty.
//     M full, dn_fire, S full               -> M<=S, S empty. in_ready was 0, so no up_fire.
//     M full, no dn_fire, up_fire (SKID=1)  -> S<=in.
//     M full, no dn_fire, no up_fire        -> M and S unchanged. Hold freezes content.
//   Flush=1 at an edge, regardless of hold/in_valid/out_ready:
//     M.valid<=0, S.valid<=0.
//     An up_fire in the same cycle is accepted and discarded.
//     A dn_fire in the same cycle completes; downstream owns that entry.
//     drop_cnt += (M.valid & ~dn_fire) + S.valid + up_fire, saturating at all-ones, no wrap.
//     Next cycle: out_valid=0, out_data=BUBBLE_DATA, in_ready=1.
//   Ordering: entries leave in arrival order. S is never valid while M is empty.
//   occupancy = M.valid + S.valid, registered.
//   Reset asserted mid-transfer: entries lost, drop_cnt cleared, no output glitch beyond reset values.
// TESTING
//   T1 reset:
//     rst_n=0 mid-stream -> out_valid=0, out_data=BUBBLE_DATA, occupancy=0, drop_cnt=0, in_ready=1.
//   T2 streaming:
//     10 entries data=i, pc=i+1, out_ready=1 -> out_data=i exactly 1 cycle later, no gaps, in order.
//   T3 stall/skid (SKID=1):
//     hold=1 while 3 entries offered -> 2 accepted, in_ready=0 after 2nd, occupancy=2.
//     Release hold -> entries 0,1,2 emerge in order, no loss.
//   T4 flush beats hold:
//     hold=1, occupancy=2, flush=1 with in_valid=0 -> next cycle out_valid=0, occupancy=0, drop_cnt=2.
//   T5 flush with simultaneous fires:
//     M full, out_ready=1, in_valid=1, flush=1 -> M counted delivered, input dropped.
//     Result: drop_cnt+=1, out_valid=0 next cycle.
//   T6 counter saturation and SKID=0:
//     CNT_W=2, 5 single-entry flushes -> drop_cnt stays 3.
//     SKID=0, hold=1, M full -> in_ready=0 the same cycle.

Source files
------------

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// pipe_stage_buf : valid/ready inter-stage register, optional 2-entry skid,
//                  hold/flush control and a saturating flush-drop counter.
// Revision 1.0
// ============================================================================
module pipe_stage_buf #(
  parameter int                DATA_W      = 32,
  parameter int                PC_W        = 32,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
  parameter int                SKID        = 1,
  parameter int                CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [PC_W-1:0]   r_m_pc;
  logic              w_s_valid;
  logic [DATA_W-1:0] w_s_data;
  logic [PC_W-1:0]   w_s_pc;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              w_up_fire;
  logic              w_dn_fire;
  logic [1:0]        w_drop_inc;
  logic [CNT_W:0]    w_drop_sum;

  assign w_dn_fire = r_m_valid & out_ready & ~hold;
  assign w_up_fire = in_valid & in_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_s_valid;
      logic [DATA_W-1:0] r_s_data;
      logic [PC_W-1:0]   r_s_pc;

      // S only fills while M is stalled, so it always holds the younger entry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s_valid <= 1'b0;
          r_s_data  <= '0;
          r_s_pc    <= '0;
        end else if (flush || w_dn_fire) begin
          r_s_valid <= 1'b0;
        end else if (r_m_valid && w_up_fire) begin
          r_s_valid <= 1'b1;
          r_s_data  <= in_data;
          r_s_pc    <= in_pc;
        end
      end

      assign in_ready  = ~r_s_valid;
      assign w_s_valid = r_s_valid;
      assign w_s_data  = r_s_data;
      assign w_s_pc    = r_s_pc;
    end else begin : g_no_skid
      assign in_ready  = ~r_m_valid | (out_ready & ~hold);
      assign w_s_valid = 1'b0;
      assign w_s_data  = '0;
      assign w_s_pc    = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_pc    <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
    end else if (!r_m_valid || w_dn_fire) begin
      if (w_s_valid) begin
        r_m_data <= w_s_data;
        r_m_pc   <= w_s_pc;
      end else if (w_up_fire) begin
        r_m_valid <= 1'b1;
        r_m_data  <= in_data;
        r_m_pc    <= in_pc;
      end else begin
        r_m_valid <= 1'b0;
      end
    end
  end

  // An entry leaving via dn_fire during a flush belongs to downstream, not dropped.
  assign w_drop_inc = {1'b0, r_m_valid & ~w_dn_fire} + {1'b0, w_s_valid} + {1'b0, w_up_fire};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_drop_cnt <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
    end
  end

  assign out_valid = r_m_valid;
  assign out_data  = r_m_valid ? r_m_data : BUBBLE_DATA;
  assign out_pc    = r_m_valid ? r_m_pc : '0;
  assign occupancy = {1'b0, r_m_valid} + {1'b0, w_s_valid};
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
